mips_instr_mem: RTL and testbench

MIPS_INSTR_MEM -- requirements
Module: mips_instr_mem

---
 rtl/mips_instr_mem.sv | 139 +++++++++++++
 tb/tb_mips_instr_mem.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_mem.sv
// MIPS boot ROM style instruction memory with a load port, optional fetch wait states and
// sticky misaligned-fetch flag. Define MIPS_INSTR_MEM_MONITOR_EN to build the run monitor.
module mips_instr_mem #(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 200,
    parameter int unsigned BYTE_SWAP   = 1,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [31:0]      instr_address,
    output logic [31:0]      instr_readdata,
    output logic             instr_valid,
    output logic             addr_err,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [31:0]      load_data,
    input  logic             active,
    output logic             run_done,
    output logic             timed_out,
    output logic [31:0]      cycle_count
);

    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [31:0]      offset;
    logic [31:0]      word;
    logic [IDX_W-1:0] idx;
    logic             aligned;
    logic             in_range;

    // Address decode; the offset compare also rejects addresses that wrap past the top
    assign offset   = instr_address - BASE_ADDR;
    assign aligned  = (instr_address[1:0] == 2'b00);
    assign in_range = (instr_address >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];
    assign word     = mem[idx];

    // Out-of-range and misaligned fetches return a NOP
    always_comb begin
        instr_readdata = 32'd0;
        if (in_range && aligned) begin
            if (BYTE_SWAP != 0) begin
                instr_readdata = {word[7:0], word[15:8], word[23:16], word[31:24]};
            end else begin
                instr_readdata = word;
            end
        end
    end

    // Load port ignores clk_enable and reset so programs can be written while held in reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_err <= 1'b0;
        end else if (clk_enable && !aligned) begin
            addr_err <= 1'b1;
        end
    end

    generate
        if (WAIT_STATES == 0) begin : g_no_wait
            assign instr_valid = 1'b1;
        end else begin : g_wait
            localparam int unsigned CNT_W = (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
            localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

            typedef enum logic {ST_READY, ST_WAIT} state_t;

            state_t           state;
            logic [31:0]      last_addr;
            logic [CNT_W-1:0] count;

            // Any address change (re)starts the wait; data valid WAIT_STATES cycles later
            always_ff @(posedge clk) begin
                if (!reset) begin
                    state     <= ST_READY;
                    last_addr <= BASE_ADDR;
                    count     <= '0;
                end else if (clk_enable) begin
                    if (instr_address != last_addr) begin
                        state     <= ST_WAIT;
                        last_addr <= instr_address;
                        count     <= CNT_LOAD;
                    end else if (state == ST_WAIT) begin
                        if (count <= CNT_W'(1)) begin
                            state <= ST_READY;
                            count <= '0;
                        end else begin
                            count <= count - CNT_W'(1);
                        end
                    end
                end
            end

            assign instr_valid = reset && (state == ST_READY) && (instr_address == last_addr);
        end
    endgenerate

`ifdef MIPS_INSTR_MEM_MONITOR_EN
    logic done_hit;

    assign done_hit = (instr_address == 32'd0) && !active;

    // Counter stops on the edge that raises either flag; run_done wins a tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            run_done    <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= 32'd0;
        end else if (clk_enable && !run_done && !timed_out) begin
            if (done_hit) begin
                run_done <= 1'b1;
            end else if (cycle_count == 32'(TIMEOUT - 1)) begin
                timed_out <= 1'b1;
            end else begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end
`else
    logic unused_active;

    assign unused_active = active;
    assign run_done      = 1'b0;
    assign timed_out     = 1'b0;
    assign cycle_count   = 32'd0;
`endif

endmodule

// File: tb/tb_mips_instr_mem.sv
// Directed plus randomized bench for mips_instr_mem: a zero-wait instance and a two-wait-state instance.
module tb_mips_instr_mem;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hBFC00000;
`ifdef MIPS_INSTR_MEM_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        active;

    logic [31:0] d_readdata, w_readdata;
    logic        d_valid, w_valid, d_err, w_err;
    logic        d_done, w_done, d_tout, w_tout;
    logic [31:0] d_count, w_count;

    logic [31:0] model_mem [DEPTH];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] old_exp;

    always #5 clk = ~clk;

    mips_instr_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .TIMEOUT(20), .BYTE_SWAP(1)) u_dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(d_readdata), .instr_valid(d_valid), .addr_err(d_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .active(active),
        .run_done(d_done), .timed_out(d_tout), .cycle_count(d_count)
    );

    mips_instr_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2), .TIMEOUT(200), .BYTE_SWAP(1)) u_ws (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .instr_address(instr_address),
        .instr_readdata(w_readdata), .instr_valid(w_valid), .addr_err(w_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .active(active),
        .run_done(w_done), .timed_out(w_tout), .cycle_count(w_count)
    );

    // Reference fetch: range and alignment by plain arithmetic, then byte reversal by shifts
    function automatic logic [31:0] exp_fetch(input logic [31:0] a);
        longint unsigned la = longint'(a);
        longint unsigned lo = longint'(BASE);
        logic [31:0] w;
        if ((la % 4) != 0 || la < lo || la >= lo + 4 * DEPTH) return 32'd0;
        w = model_mem[int'((la - lo) / 4)];
        return ((w & 32'hFF) << 24) | (((w >> 8) & 32'hFF) << 16) |
               (((w >> 16) & 32'hFF) << 8) | ((w >> 24) & 32'hFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; clk_enable = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        instr_address = BASE; active = 1'b1;

        // Program the whole memory while held in reset with clk_enable low
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 6'(i);
            load_data = (i == 0) ? 32'h24010020 : $urandom;
            model_mem[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;

        chk("rst_addr_err", 32'(d_err), 32'd0);
        chk("rst_run_done", 32'(d_done), 32'd0);
        chk("rst_timed_out", 32'(d_tout), 32'd0);
        chk("rst_cycle_count", d_count, 32'd0);
        chk("rst_ws_valid", 32'(w_valid), 32'd0);
        chk("rst_nowait_valid", 32'(d_valid), 32'd1);

        reset = 1'b1; clk_enable = 1'b1;
        #1;
        chk("word0_swapped", d_readdata, 32'h20000124);
        chk("word0_valid", 32'(d_valid), 32'd1);
        chk("ws_valid_at_base", 32'(w_valid), 32'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            instr_address = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            #1;
            chk("rand_fetch", d_readdata, exp_fetch(instr_address));
        end

        @(negedge clk); instr_address = BASE + 32'd252; #1;
        chk("last_word", d_readdata, exp_fetch(instr_address));
        @(negedge clk); instr_address = 32'hBFC00100; #1;
        chk("past_end", d_readdata, 32'd0);
        @(negedge clk); instr_address = BASE - 32'd4; #1;
        chk("below_base", d_readdata, 32'd0);
        chk("no_err_aligned", 32'(d_err), 32'd0);

        // Misaligned fetch: flag only on an enabled edge, then sticky
        @(negedge clk); clk_enable = 1'b0; instr_address = 32'hBFC00002; #1;
        chk("misaligned_nop", d_readdata, 32'd0);
        step(1);
        chk("err_gated", 32'(d_err), 32'd0);
        clk_enable = 1'b1;
        step(1);
        chk("err_set", 32'(d_err), 32'd1);
        instr_address = BASE;
        step(2);
        chk("err_sticky", 32'(d_err), 32'd1);

        // Load and fetch the same word in one cycle
        @(negedge clk);
        instr_address = BASE + 32'd20;
        old_exp   = exp_fetch(instr_address);
        load_en   = 1'b1; load_addr = 6'd5; load_data = $urandom;
        #1;
        chk("load_same_cycle_old", d_readdata, old_exp);
        @(negedge clk);
        model_mem[5] = load_data;
        load_en = 1'b0;
        chk("load_next_cycle_new", d_readdata, exp_fetch(instr_address));

        // Wait-state instance
        instr_address = BASE;
        step(3);
        chk("ws_settled", 32'(w_valid), 32'd1);
        instr_address = BASE + 32'd4; #1;
        chk("ws_low_c0", 32'(w_valid), 32'd0);
        step(1);
        chk("ws_low_c1", 32'(w_valid), 32'd0);
        step(1);
        chk("ws_high_c2", 32'(w_valid), 32'd1);
        chk("ws_data", w_readdata, exp_fetch(instr_address));

        @(negedge clk); instr_address = BASE + 32'd8; #1;
        chk("ws_rs_c0", 32'(w_valid), 32'd0);
        @(negedge clk); instr_address = BASE + 32'd12; #1;
        chk("ws_rs_c1", 32'(w_valid), 32'd0);
        step(1);
        chk("ws_rs_c2", 32'(w_valid), 32'd0);
        step(1);
        chk("ws_rs_c3", 32'(w_valid), 32'd1);

        @(negedge clk); instr_address = BASE + 32'd16; clk_enable = 1'b0;
        step(3);
        chk("ws_frozen", 32'(w_valid), 32'd0);
        clk_enable = 1'b1;
        step(2);
        chk("ws_resume", 32'(w_valid), 32'd1);

        @(negedge clk); instr_address = BASE + 32'd20;
        step(1);
        reset = 1'b0; #1;
        chk("ws_valid_in_reset", 32'(w_valid), 32'd0);
        step(1);
        chk("err_cleared", 32'(d_err), 32'd0);
        reset = 1'b1; instr_address = BASE; #1;
        chk("ws_abort_ready", 32'(w_valid), 32'd1);

        // Run monitor: done after 10 enabled cycles
        reset = 1'b0;
        step(1);
        reset = 1'b1; active = 1'b1; instr_address = BASE;
        step(10);
        clk_enable = 1'b0;
        step(3);
        chk("mon_count_10", d_count, MON ? 32'd10 : 32'd0);
        clk_enable = 1'b1; instr_address = 32'd0; active = 1'b0;
        step(1);
        chk("mon_run_done", 32'(d_done), MON ? 32'd1 : 32'd0);
        chk("mon_ws_run_done", 32'(w_done), MON ? 32'd1 : 32'd0);
        step(3);
        chk("mon_done_frozen", d_count, MON ? 32'd10 : 32'd0);
        chk("mon_no_timeout", 32'(d_tout), 32'd0);

        // Run monitor: timeout at 20 enabled cycles
        reset = 1'b0;
        step(1);
        reset = 1'b1; active = 1'b1; instr_address = BASE;
        step(19);
        chk("tmo_pre_count", d_count, MON ? 32'd19 : 32'd0);
        chk("tmo_pre_flag", 32'(d_tout), 32'd0);
        step(1);
        chk("tmo_flag", 32'(d_tout), MON ? 32'd1 : 32'd0);
        chk("tmo_count", d_count, MON ? 32'd19 : 32'd0);
        chk("tmo_ws_count", w_count, MON ? 32'd20 : 32'd0);
        chk("tmo_ws_flag", 32'(w_tout), 32'd0);
        step(5);
        chk("tmo_frozen", d_count, MON ? 32'd19 : 32'd0);
        chk("tmo_no_done", 32'(d_done), 32'd0);

        reset = 1'b0;
        step(1);
        chk("rst2_timed_out", 32'(d_tout), 32'd0);
        chk("rst2_run_done", 32'(d_done), 32'd0);
        chk("rst2_count", d_count, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr_address = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            #1;
            chk("mem_retained", d_readdata, exp_fetch(instr_address));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
